// File: rtl/input_port_ctrl.sv
// Router input stage: FIFO-buffered flits, route latched per packet, switch request until tail forwarded.
// Push-to-forward latency 2 cycles, 1-cycle bubble between packets; ready_out = !full, pops only on sa_grant or drop.
module input_port_ctrl #(
  parameter int MSB_SLOT  = 5,
  parameter int DSIZE     = 1 << MSB_SLOT,
  parameter int DEPTH_LOG = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DSIZE-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [DSIZE-1:0] route_flit,
  input  logic [2:0]       route_in,
  output logic             sa_req,
  output logic [2:0]       sa_port,
  input  logic             sa_grant,
  output logic [DSIZE-1:0] data_out,
  output logic [7:0]       drop_cnt
);

  localparam int               DEPTH    = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = {1'b1, {DEPTH_LOG{1'b0}}};
  localparam logic [2:0]       PORT_INV = 3'b111;
  localparam logic [1:0]       T_HEAD   = 2'b11;
  localparam logic [1:0]       T_TAIL   = 2'b10;

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

  state_t                 state;
  logic [DSIZE-1:0]       mem [DEPTH];
  logic [DEPTH_LOG-1:0]   rd_ptr;
  logic [DEPTH_LOG-1:0]   wr_ptr;
  logic [DEPTH_LOG:0]     count;
  logic                   empty;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [DSIZE-1:0]       head_flit;
  logic [1:0]             head_type;

  assign empty      = (count == '0);
  assign full       = (count == FULL_CNT);
  assign push       = valid_in && !full;
  assign head_flit  = mem[rd_ptr];
  assign head_type  = head_flit[1:0];
  assign ready_out  = !full;
  assign route_flit = empty ? '0 : head_flit;
  assign data_out   = empty ? '0 : head_flit;
  assign sa_req     = (state == ACTIVE) && !empty;

  // Drops happen for stray non-head flits and unroutable heads in IDLE, and everything in DROP.
  always_comb begin
    pop  = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (head_type != T_HEAD || route_in == PORT_INV)) begin
          pop  = 1'b1;
          drop = 1'b1;
        end
      end
      ACTIVE: pop = sa_req && sa_grant;
      DROP: begin
        pop  = !empty;
        drop = !empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sa_port  <= PORT_INV;
      drop_cnt <= '0;
    end else begin
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (!empty && head_type == T_HEAD) begin
            if (route_in != PORT_INV) begin
              state   <= ACTIVE;
              sa_port <= route_in;
            end else begin
              state <= DROP;
            end
          end
        end
        ACTIVE: begin
          // A type-11 flit mid-packet is ordinary payload; only the tail closes the packet.
          if (pop && head_type == T_TAIL) begin
            state   <= IDLE;
            sa_port <= PORT_INV;
          end
        end
        DROP: begin
          if (pop && head_type == T_TAIL) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          sa_port <= PORT_INV;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl: cycle table for a basic packet, scoreboard on every forwarded flit.
module tb_input_port_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] route_flit;
  logic [2:0]  route_in;
  logic        sa_req;
  logic [2:0]  sa_port;
  logic        sa_grant;
  logic [31:0] data_out;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int req_cycles = 0;
  int r0;
  logic [34:0] sb_q[$];
  logic [34:0] exp_fwd;

  typedef struct {
    logic        vld;
    logic [31:0] dat;
    logic        exp_req;
    logic [2:0]  exp_port;
    logic [31:0] exp_dout;
    logic        exp_rdy;
  } vec_t;

  vec_t tbl[6];

  always #5 clk = ~clk;

  input_port_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .route_flit (route_flit),
    .route_in   (route_in),
    .sa_req     (sa_req),
    .sa_port    (sa_port),
    .sa_grant   (sa_grant),
    .data_out   (data_out),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_flit(input logic [31:0] d, input logic fwd, input logic [2:0] port);
    int n = 0;
    valid_in = 1'b1;
    data_in  = d;
    while (!ready_out && n < 100) begin
      step();
      n++;
    end
    if (!ready_out) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: ready_out %b for flit %h, required 1", ready_out, d);
    end else if (fwd) begin
      sb_q.push_back({port, d});
    end
    step();
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(route_flit == 32'd0 && sa_port == 3'b111) && n < 60) begin
      step();
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: route_flit %h sa_port %0d, required 0 and 7", route_flit, sa_port);
    end
  endtask

  // Forwards are observed mid-cycle; the pop happens at the following rising edge.
  always @(negedge clk) begin
    if (reset && sa_req) req_cycles++;
    if (reset && sa_req && sa_grant) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fwd_unexpected: got data %h port %0d, required no forward", data_out, sa_port);
      end else begin
        exp_fwd = sb_q.pop_front();
        chk("fwd_data", data_out, exp_fwd[31:0]);
        chk("fwd_port", 32'(sa_port), 32'(exp_fwd[34:32]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    valid_in = 1'b0;
    data_in  = '0;
    route_in = 3'b111;
    sa_grant = 1'b0;

    tbl[0] = '{1'b1, 32'h0201_0003, 1'b0, 3'd7, 32'h0000_0000, 1'b1};
    tbl[1] = '{1'b1, 32'h0201_0001, 1'b0, 3'd7, 32'h0201_0003, 1'b1};
    tbl[2] = '{1'b1, 32'h0201_0002, 1'b1, 3'd2, 32'h0201_0003, 1'b1};
    tbl[3] = '{1'b0, 32'h0000_0000, 1'b1, 3'd2, 32'h0201_0001, 1'b1};
    tbl[4] = '{1'b0, 32'h0000_0000, 1'b1, 3'd2, 32'h0201_0002, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0000, 1'b0, 3'd7, 32'h0000_0000, 1'b1};

    #12;
    chk("rst_sa_req", 32'(sa_req), 32'd0);
    chk("rst_sa_port", 32'(sa_port), 32'd7);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_route_flit", route_flit, 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    reset = 1'b1;
    step();

    // Basic packet, cycle by cycle
    route_in = 3'b010;
    sa_grant = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("basic_req[%0d]", i), 32'(sa_req), 32'(tbl[i].exp_req));
      chk($sformatf("basic_port[%0d]", i), 32'(sa_port), 32'(tbl[i].exp_port));
      chk($sformatf("basic_dout[%0d]", i), data_out, tbl[i].exp_dout);
      chk($sformatf("basic_route_flit[%0d]", i), route_flit, tbl[i].exp_dout);
      chk($sformatf("basic_rdy[%0d]", i), 32'(ready_out), 32'(tbl[i].exp_rdy));
      valid_in = tbl[i].vld;
      data_in  = tbl[i].dat;
      if (tbl[i].vld) sb_q.push_back({3'b010, tbl[i].dat});
      step();
    end
    valid_in = 1'b0;
    chk("basic_sb_empty", 32'(sb_q.size()), 32'd0);

    // Backpressure: fill with grant low, hold the 5th, then drain and wrap pointers
    route_in = 3'b011;
    sa_grant = 1'b0;
    push_flit(32'h0300_0003, 1'b1, 3'd3);
    push_flit(32'h0300_0101, 1'b1, 3'd3);
    push_flit(32'h0300_0201, 1'b1, 3'd3);
    push_flit(32'h0300_0301, 1'b1, 3'd3);
    chk("full_ready", 32'(ready_out), 32'd0);
    chk("full_head", route_flit, 32'h0300_0003);
    chk("full_port", 32'(sa_port), 32'd3);
    chk("full_req", 32'(sa_req), 32'd1);
    valid_in = 1'b1;
    data_in  = 32'h0300_0401;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_hold", 32'(ready_out), 32'd0);
    end
    sa_grant = 1'b1;
    push_flit(32'h0300_0401, 1'b1, 3'd3);
    push_flit(32'h0300_0501, 1'b1, 3'd3);
    push_flit(32'h0300_060B, 1'b1, 3'd3);
    push_flit(32'h0300_0701, 1'b1, 3'd3);
    push_flit(32'h0300_0802, 1'b1, 3'd3);
    wait_idle();
    chk("wrap_port_idle", 32'(sa_port), 32'd7);
    chk("wrap_sb_empty", 32'(sb_q.size()), 32'd0);

    // Invalid route: whole packet discarded, then a good packet goes through
    route_in = 3'b111;
    r0 = req_cycles;
    push_flit(32'h0400_0003, 1'b0, 3'd7);
    push_flit(32'h0400_0101, 1'b0, 3'd7);
    push_flit(32'h0400_0201, 1'b0, 3'd7);
    push_flit(32'h0400_0302, 1'b0, 3'd7);
    wait_idle();
    chk("inv_drop_cnt", 32'(drop_cnt), 32'd4);
    chk("inv_no_req", 32'(req_cycles - r0), 32'd0);
    route_in = 3'b100;
    push_flit(32'h0500_0003, 1'b1, 3'd4);
    push_flit(32'h0500_0102, 1'b1, 3'd4);
    wait_idle();
    chk("inv_next_sb_empty", 32'(sb_q.size()), 32'd0);

    // Stray non-head flits (types 00 and 01) and counter saturation
    r0 = req_cycles;
    for (int i = 0; i < 100; i++) push_flit({8'h06, 16'(i), 7'd0, i[0]}, 1'b0, 3'd7);
    wait_idle();
    chk("stray_drop_104", 32'(drop_cnt), 32'd104);
    for (int i = 100; i < 300; i++) push_flit({8'h06, 16'(i), 7'd0, i[0]}, 1'b0, 3'd7);
    wait_idle();
    chk("stray_drop_sat", 32'(drop_cnt), 32'd255);
    chk("stray_no_req", 32'(req_cycles - r0), 32'd0);

    // Asynchronous reset while ACTIVE with 3 flits buffered
    route_in = 3'b001;
    sa_grant = 1'b0;
    push_flit(32'h0700_0003, 1'b1, 3'd1);
    push_flit(32'h0700_0101, 1'b1, 3'd1);
    push_flit(32'h0700_0201, 1'b1, 3'd1);
    chk("prerst_req", 32'(sa_req), 32'd1);
    chk("prerst_port", 32'(sa_port), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_req", 32'(sa_req), 32'd0);
    chk("midrst_port", 32'(sa_port), 32'd7);
    chk("midrst_ready", 32'(ready_out), 32'd1);
    chk("midrst_dout", data_out, 32'd0);
    chk("midrst_route_flit", route_flit, 32'd0);
    chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
    sb_q.delete();
    #3;
    reset = 1'b1;
    step();
    sa_grant = 1'b1;
    push_flit(32'h0800_0003, 1'b1, 3'd1);
    push_flit(32'h0800_0102, 1'b1, 3'd1);
    wait_idle();
    chk("postrst_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("postrst_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
